// File: rtl/cnn_layer_sched_if.sv
// rtl/cnn_layer_sched_if.sv - handshake/config/memory-address bundle for cnn_layer_sched
interface cnn_layer_sched_if;
  logic        start;
  logic [13:0] cfg_w_base;
  logic [11:0] cfg_in_base;
  logic [11:0] cfg_out_base;
  logic [11:0] cfg_num_tiles;
  logic [13:0] cfg_num_kern;
  logic [13:0] addr_weight;
  logic [11:0] addr_src;
  logic [11:0] addr_dst;
  logic        we_dst;
  logic        bank_sel;
  logic        pe_start;
  logic        pe_done;
  logic        busy;
  logic        done;
  logic        err;

  // Environment side: issues layer requests and PE completions.
  modport master (
    output start, cfg_w_base, cfg_in_base, cfg_out_base, cfg_num_tiles, cfg_num_kern, pe_done,
    input  addr_weight, addr_src, addr_dst, we_dst, bank_sel, pe_start, busy, done, err
  );

  // Scheduler side.
  modport slave (
    input  start, cfg_w_base, cfg_in_base, cfg_out_base, cfg_num_tiles, cfg_num_kern, pe_done,
    output addr_weight, addr_src, addr_dst, we_dst, bank_sel, pe_start, busy, done, err
  );
endinterface

// File: rtl/cnn_layer_sched.sv
// rtl/cnn_layer_sched.sv - layer sequencer for the conv datapath (optional PE watchdog: PE_WDT_EN)
module cnn_layer_sched #(
  parameter int RD_LAT     = 2,
  parameter int WDT_CYCLES = 1024
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  cnn_layer_sched_if.slave sched_if
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_PE_RUN  = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_NEXT    = 3'd5;
  localparam logic [2:0] S_FIN     = 3'd6;

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  logic [2:0]  state_q, state_d;
  logic [13:0] k_q, k_d;
  logic [11:0] t_q, t_d;
  logic [11:0] wcnt_q, wcnt_d;
  logic [2:0]  lat_q, lat_d;
  logic [13:0] w_base_q, w_base_d;
  logic [11:0] in_base_q, in_base_d;
  logic [11:0] out_base_q, out_base_d;
  logic [11:0] num_tiles_q, num_tiles_d;
  logic [13:0] num_kern_q, num_kern_d;
  logic        pe_start_q, pe_start_d;
  logic        we_dst_q, we_dst_d;
  logic [11:0] addr_dst_q, addr_dst_d;
  logic        done_q, done_d;
  logic        bank_sel_q, bank_sel_d;

`ifdef PE_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             err_q, err_d;
  logic             abort_q, abort_d;
`endif

  // Next-state and registered-output computation for the layer sequence.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    t_d         = t_q;
    wcnt_d      = wcnt_q;
    lat_d       = lat_q;
    w_base_d    = w_base_q;
    in_base_d   = in_base_q;
    out_base_d  = out_base_q;
    num_tiles_d = num_tiles_q;
    num_kern_d  = num_kern_q;
    addr_dst_d  = addr_dst_q;
    bank_sel_d  = bank_sel_q;
    pe_start_d  = 1'b0;
    we_dst_d    = 1'b0;
    done_d      = 1'b0;
`ifdef PE_WDT_EN
    wdt_d       = wdt_q;
    err_d       = err_q;
    abort_d     = abort_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (sched_if.start) begin
          if ((sched_if.cfg_num_kern == 14'd0) || (sched_if.cfg_num_tiles == 12'd0)) begin
            state_d = S_FIN;
          end else begin
            w_base_d    = sched_if.cfg_w_base;
            in_base_d   = sched_if.cfg_in_base;
            out_base_d  = sched_if.cfg_out_base;
            num_tiles_d = sched_if.cfg_num_tiles;
            num_kern_d  = sched_if.cfg_num_kern;
            k_d         = 14'd0;
            t_d         = 12'd0;
            wcnt_d      = 12'd0;
            state_d     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        lat_d   = 3'd0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          pe_start_d = 1'b1;
          state_d    = S_PE_RUN;
`ifdef PE_WDT_EN
          wdt_d      = '0;
`endif
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_PE_RUN: begin
        if (sched_if.pe_done) begin
          state_d = S_WRITE;
        end
`ifdef PE_WDT_EN
        else if (wdt_q == WDT_LAST) begin
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wdt_d = wdt_q + 1'b1;
        end
`endif
      end
      S_WRITE: begin
        we_dst_d   = 1'b1;
        addr_dst_d = out_base_q + wcnt_q;
        wcnt_d     = wcnt_q + 12'd1;
        state_d    = S_NEXT;
      end
      S_NEXT: begin
        if (t_q != (num_tiles_q - 12'd1)) begin
          t_d     = t_q + 12'd1;
          state_d = S_FETCH;
        end else begin
          t_d = 12'd0;
          if (k_q != (num_kern_q - 14'd1)) begin
            k_d     = k_q + 14'd1;
            state_d = S_FETCH;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef PE_WDT_EN
        // An aborted layer produced no valid output bank, so roles stay put.
        if (!abort_q) bank_sel_d = ~bank_sel_q;
        abort_d = 1'b0;
`else
        bank_sel_d = ~bank_sel_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any layer in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      t_q         <= '0;
      wcnt_q      <= '0;
      lat_q       <= '0;
      w_base_q    <= '0;
      in_base_q   <= '0;
      out_base_q  <= '0;
      num_tiles_q <= '0;
      num_kern_q  <= '0;
      pe_start_q  <= 1'b0;
      we_dst_q    <= 1'b0;
      addr_dst_q  <= '0;
      done_q      <= 1'b0;
      bank_sel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      t_q         <= t_d;
      wcnt_q      <= wcnt_d;
      lat_q       <= lat_d;
      w_base_q    <= w_base_d;
      in_base_q   <= in_base_d;
      out_base_q  <= out_base_d;
      num_tiles_q <= num_tiles_d;
      num_kern_q  <= num_kern_d;
      pe_start_q  <= pe_start_d;
      we_dst_q    <= we_dst_d;
      addr_dst_q  <= addr_dst_d;
      done_q      <= done_d;
      bank_sel_q  <= bank_sel_d;
    end
  end

`ifdef PE_WDT_EN
  // Watchdog counter, sticky error and abort marker.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_q   <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      wdt_q   <= wdt_d;
      err_q   <= err_d;
      abort_q <= abort_d;
    end
  end

  assign sched_if.err = err_q;
`else
  assign sched_if.err = 1'b0;
`endif

  // Read addresses follow the live k/t counters, which only move in NEXT,
  // so they hold steady from FETCH through the whole PE pass.
  assign sched_if.addr_weight = w_base_q + k_q;
  assign sched_if.addr_src    = in_base_q + t_q;
  assign sched_if.addr_dst    = addr_dst_q;
  assign sched_if.we_dst      = we_dst_q;
  assign sched_if.pe_start    = pe_start_q;
  assign sched_if.done        = done_q;
  assign sched_if.bank_sel    = bank_sel_q;
  assign sched_if.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnn_layer_sched.sv
// tb/tb_cnn_layer_sched.sv - directed self-checking bench for cnn_layer_sched
module tb_cnn_layer_sched;

  logic clk;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  cnn_layer_sched_if bus ();

  cnn_layer_sched #(
    .RD_LAT     (2),
    .WDT_CYCLES (16)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .sched_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: counts rising edges.
  always @(posedge clk) cyc <= cyc + 1;

  // PE model: pe_done pulses pe_delay cycles after pe_start (0 = same cycle, <0 = never).
  int   pe_delay;
  int   pe_left;
  logic auto_done;
  logic stray_done;
  assign bus.pe_done = auto_done | stray_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      auto_done = 1'b0;
      pe_left   = 0;
    end else begin
      auto_done = 1'b0;
      if (pe_left > 0) begin
        pe_left = pe_left - 1;
        if (pe_left == 0) auto_done = 1'b1;
      end
      if (bus.pe_start && pe_delay >= 0) begin
        if (pe_delay == 0) auto_done = 1'b1;
        else pe_left = pe_delay;
      end
    end
  end

  // Event monitor.
  logic [11:0] log_dst [64];
  logic [13:0] log_w   [64];
  logic [11:0] log_src [64];
  int we_cnt, pe_cnt, done_cnt;
  int first_pe_cyc, first_we_cyc, done_cyc;

  always @(negedge clk) begin
    if (bus.we_dst) begin
      if (we_cnt < 64) begin
        log_dst[we_cnt] = bus.addr_dst;
        log_w[we_cnt]   = bus.addr_weight;
        log_src[we_cnt] = bus.addr_src;
      end
      if (we_cnt == 0) first_we_cyc = cyc;
      we_cnt = we_cnt + 1;
    end
    if (bus.pe_start) begin
      if (pe_cnt == 0) first_pe_cyc = cyc;
      pe_cnt = pe_cnt + 1;
    end
    if (bus.done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    we_cnt       = 0;
    pe_cnt       = 0;
    done_cnt     = 0;
    first_pe_cyc = -1;
    first_we_cyc = -1;
    done_cyc     = -1;
  endtask

  // Present a layer request for one cycle; cfg is scrambled afterwards to prove it was latched.
  task automatic start_layer(input int k, input int t, input int wb, input int ib, input int ob,
                             output int c0);
    bus.cfg_num_kern  = 14'(k);
    bus.cfg_num_tiles = 12'(t);
    bus.cfg_w_base    = 14'(wb);
    bus.cfg_in_base   = 12'(ib);
    bus.cfg_out_base  = 12'(ob);
    bus.start         = 1'b1;
    c0                = cyc;
    step();
    bus.start         = 1'b0;
    bus.cfg_num_kern  = 14'h3FFF;
    bus.cfg_num_tiles = 12'hABC;
    bus.cfg_w_base    = 14'h1555;
    bus.cfg_in_base   = 12'h777;
    bus.cfg_out_base  = 12'h333;
  endtask

  task automatic wait_layer(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    check({tag, "_done_seen"}, (done_cnt != 0), 1);
    step();
  endtask

  initial begin
    int c0;
    int p0;
    errors        = 0;
    checks        = 0;
    cyc           = 0;
    pe_delay      = 4;
    stray_done    = 1'b0;
    bus.start     = 1'b0;
    bus.cfg_num_kern  = '0;
    bus.cfg_num_tiles = '0;
    bus.cfg_w_base    = '0;
    bus.cfg_in_base   = '0;
    bus.cfg_out_base  = '0;
    clear_logs();
    rst_n = 1'b0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_outputs", {bus.we_dst, bus.pe_start, bus.done, bus.bank_sel, bus.err}, 0);
    check("rst_addrs", {bus.addr_weight, bus.addr_src, bus.addr_dst}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Main layer: K=2, T=3.
    clear_logs();
    start_layer(2, 3, 'h10, 'h20, 'h100, c0);
    check("t1_busy", bus.busy, 1);
    wait_layer("t1", 200);
    check("t1_we_cnt", we_cnt, 6);
    check("t1_pe_cnt", pe_cnt, 6);
    check("t1_done_cnt", done_cnt, 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_addr_dst%0d", i), log_dst[i], 'h100 + i);
      check($sformatf("t1_addr_w%0d", i), log_w[i], 'h10 + i / 3);
      check($sformatf("t1_addr_src%0d", i), log_src[i], 'h20 + i % 3);
    end
    check("t1_bank", bus.bank_sel, 1);
    check("t1_idle", bus.busy, 0);

    // Latency: pe_done alongside pe_start.
    clear_logs();
    pe_delay = 0;
    start_layer(1, 1, 'h5, 'h6, 'h7, c0);
    wait_layer("t2", 50);
    check("t2_pe_start_cyc", first_pe_cyc - c0, 4);
    check("t2_we_cyc", first_we_cyc - c0, 6);
    check("t2_addr_dst", log_dst[0], 'h7);
    check("t2_bank", bus.bank_sel, 0);
    pe_delay = 4;

    // Empty layer.
    clear_logs();
    start_layer(0, 5, 'h1, 'h2, 'h3, c0);
    wait_layer("t3", 20);
    check("t3_done_cyc", done_cyc - c0, 2);
    check("t3_pe_cnt", pe_cnt, 0);
    check("t3_we_cnt", we_cnt, 0);
    check("t3_bank", bus.bank_sel, 1);

    // Source address wrap.
    clear_logs();
    start_layer(1, 4, 'h0, 'hFFE, 'h0, c0);
    wait_layer("t4", 100);
    check("t4_we_cnt", we_cnt, 4);
    check("t4_src0", log_src[0], 'hFFE);
    check("t4_src1", log_src[1], 'hFFF);
    check("t4_src2", log_src[2], 'h000);
    check("t4_src3", log_src[3], 'h001);
    check("t4_bank", bus.bank_sel, 0);

    // Destination address wrap.
    clear_logs();
    start_layer(1, 2, 'h0, 'h0, 'hFFF, c0);
    wait_layer("t5", 60);
    check("t5_we_cnt", we_cnt, 2);
    check("t5_dst0", log_dst[0], 'hFFF);
    check("t5_dst1", log_dst[1], 'h000);
    check("t5_bank", bus.bank_sel, 1);

    // Reset during the second PE pass.
    clear_logs();
    pe_delay = 8;
    start_layer(1, 4, 'h2A, 'h40, 'h80, c0);
    for (int n = 0; n < 100 && pe_cnt < 2; n++) step();
    check("t6_reached_pe2", pe_cnt, 2);
    step();
    step();
    check("t6_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_bank", bus.bank_sel, 0);
    check("t6_rst_addrs", {bus.addr_weight, bus.addr_src}, 0);
    check("t6_rst_strobes", {bus.we_dst, bus.pe_start, bus.done}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    check("t6_no_done", done_cnt, 0);
    clear_logs();
    pe_delay = 4;
    start_layer(1, 4, 'h2A, 'h40, 'h80, c0);
    wait_layer("t6b", 100);
    check("t6b_we_cnt", we_cnt, 4);
    check("t6b_dst3", log_dst[3], 'h83);
    check("t6b_w3", log_w[3], 'h2A);
    check("t6b_bank", bus.bank_sel, 1);

    // Starts while busy and stray pe_done in WAIT_RD are ignored.
    clear_logs();
    start_layer(1, 2, 'h0, 'h0, 'h50, c0);
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    stray_done = 1'b1;
    step();
    step();
    stray_done = 1'b0;
    step();
    step();
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    wait_layer("t7", 100);
    check("t7_we_cyc", first_we_cyc - c0, 10);
    check("t7_we_cnt", we_cnt, 2);
    check("t7_pe_cnt", pe_cnt, 2);
    for (int n = 0; n < 10; n++) step();
    check("t7_idle_after", bus.busy, 0);
    check("t7_we_cnt_after", we_cnt, 2);
    check("t7_done_cnt", done_cnt, 1);
    check("t7_bank", bus.bank_sel, 0);

`ifdef PE_WDT_EN
    // Watchdog abort when pe_done never arrives.
    clear_logs();
    pe_delay = -1;
    start_layer(1, 1, 'h0, 'h0, 'h0, c0);
    for (int n = 0; n < 50 && pe_cnt == 0; n++) step();
    check("t8_pe_seen", pe_cnt, 1);
    p0 = first_pe_cyc;
    while (cyc < p0 + 15) step();
    check("t8_err_early", bus.err, 0);
    step();
    check("t8_err_set", bus.err, 1);
    wait_layer("t8", 20);
    check("t8_we_cnt", we_cnt, 0);
    check("t8_bank", bus.bank_sel, 0);
    clear_logs();
    pe_delay = 4;
    start_layer(1, 1, 'h0, 'h0, 'h9, c0);
    wait_layer("t8b", 50);
    check("t8b_we_cnt", we_cnt, 1);
    check("t8b_err_sticky", bus.err, 1);
    check("t8b_bank", bus.bank_sel, 1);
`else
    p0 = 0;
    check("t8_err_tied", bus.err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
